// File: rtl/step_counter.sv
// Up/down step counter with modulo wrap, en-qualified prescaler and a registered terminal-count pulse.
// Optional build macro STEP_COUNTER_SAT_EN switches the wrap behaviour to saturation at 0 / MAXVAL.
module step_counter #(
  parameter int WIDTH    = 8,
  parameter int DEFVAL   = 0,
  parameter int INCR     = 1,
  parameter int MAXVAL   = 2**WIDTH-1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam int               PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAXVAL);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MAXVAL + 1);
  localparam logic [WIDTH:0]   INCR_W = (WIDTH+1)'(INCR);
  localparam logic [WIDTH-1:0] DEF_Q  = WIDTH'(DEFVAL);
  localparam logic [PW-1:0]    PLAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]    PONE   = PW'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_r;
  logic             tc_nxt_s;
  logic [PW-1:0]    pcnt_r;
  logic [PW-1:0]    pcnt_nxt_s;

  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH:0]   up_wrap_s;
  logic [WIDTH:0]   dn_diff_s;
  logic [WIDTH:0]   dn_wrap_s;
  logic             up_over_s;
  logic             dn_under_s;
  logic [WIDTH-1:0] load_val_s;
  logic             unused_msb_s;

  // All step arithmetic is carried one bit wider than Q so MAXVAL+1 never overflows.
  assign up_sum_s    = {1'b0, q_r} + INCR_W;
  assign up_wrap_s   = up_sum_s - MOD_W;
  assign dn_diff_s   = {1'b0, q_r} - INCR_W;
  assign dn_wrap_s   = {1'b0, q_r} + MOD_W - INCR_W;
  assign up_over_s   = (up_sum_s > MAX_W);
  assign dn_under_s  = ({1'b0, q_r} < INCR_W);
  assign load_val_s  = ({1'b0, D} > MAX_W) ? MAX_W[WIDTH-1:0] : D;
  assign unused_msb_s = ^{up_wrap_s[WIDTH], dn_diff_s[WIDTH], dn_wrap_s[WIDTH]};

  // Next-state selection: clr > load > tick > hold.
  always_comb begin
    q_nxt_s    = q_r;
    tc_nxt_s   = 1'b0;
    pcnt_nxt_s = pcnt_r;
    if (clr) begin
      q_nxt_s    = DEF_Q;
      pcnt_nxt_s = PZERO;
    end else if (load) begin
      q_nxt_s    = load_val_s;
      pcnt_nxt_s = PZERO;
    end else if (en) begin
      if (pcnt_r == PLAST) begin
        pcnt_nxt_s = PZERO;
        if (dir) begin
          if (up_over_s) begin
            tc_nxt_s = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
            q_nxt_s  = MAX_W[WIDTH-1:0];
`else
            q_nxt_s  = up_wrap_s[WIDTH-1:0];
`endif
          end else begin
            q_nxt_s  = up_sum_s[WIDTH-1:0];
          end
        end else begin
          if (dn_under_s) begin
            tc_nxt_s = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
            q_nxt_s  = {WIDTH{1'b0}};
`else
            q_nxt_s  = dn_wrap_s[WIDTH-1:0];
`endif
          end else begin
            q_nxt_s  = dn_diff_s[WIDTH-1:0];
          end
        end
      end else begin
        pcnt_nxt_s = pcnt_r + PONE;
      end
    end else begin
      pcnt_nxt_s = pcnt_r;
    end
  end

  // State registers with synchronous reset; a reset discards any partial prescale count.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= DEF_Q;
      tc_r   <= 1'b0;
      pcnt_r <= PZERO;
    end else begin
      q_r    <= q_nxt_s;
      tc_r   <= tc_nxt_s;
      pcnt_r <= pcnt_nxt_s;
    end
  end

  assign Q  = q_r;
  assign tc = tc_r;

endmodule

// File: tb/tb_step_counter.sv
// Directed self-checking bench for step_counter: three instances share stimulus and differ in INCR/PRESCALE.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst, clr, load, en, dir;
  logic [3:0] D;
  logic [3:0] qa, qb, qc;
  logic       tca, tcb, tcc;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  step_counter #(.WIDTH(4), .DEFVAL(3), .INCR(4), .MAXVAL(9), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .D(D), .en(en), .dir(dir), .Q(qa), .tc(tca));
  step_counter #(.WIDTH(4), .DEFVAL(3), .INCR(1), .MAXVAL(9), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .D(D), .en(en), .dir(dir), .Q(qb), .tc(tcb));
  step_counter #(.WIDTH(4), .DEFVAL(3), .INCR(1), .MAXVAL(9), .PRESCALE(3)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .D(D), .en(en), .dir(dir), .Q(qc), .tc(tcc));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b1; D = 4'd0;
    step();
    chk("rst_q", {4'd0, qa}, 8'd3);
    chk("rst_tc", {7'd0, tca}, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_q", {4'd0, qa}, 8'd3);
      chk("hold_tc", {7'd0, tca}, 8'd0);
    end

    // Up wrap with INCR=4 from 8
    load = 1'b1; D = 4'd8;
    step();
    chk("load8", {4'd0, qa}, 8'd8);
    load = 1'b0; en = 1'b1; dir = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
    step(); chk("sat_up1_q", {4'd0, qa}, 8'd9); chk("sat_up1_tc", {7'd0, tca}, 8'd1);
    step(); chk("sat_up2_q", {4'd0, qa}, 8'd9); chk("sat_up2_tc", {7'd0, tca}, 8'd1);
`else
    step(); chk("up1_q", {4'd0, qa}, 8'd2); chk("up1_tc", {7'd0, tca}, 8'd1);
    step(); chk("up2_q", {4'd0, qa}, 8'd6); chk("up2_tc", {7'd0, tca}, 8'd0);
    step(); chk("up3_q", {4'd0, qa}, 8'd0); chk("up3_tc", {7'd0, tca}, 8'd1);
    step(); chk("up4_q", {4'd0, qa}, 8'd4); chk("up4_tc", {7'd0, tca}, 8'd0);
`endif

    // Down with INCR=4 from 2
    en = 1'b0; load = 1'b1; D = 4'd2;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b0;
`ifdef STEP_COUNTER_SAT_EN
    step(); chk("sat_dn1_q", {4'd0, qa}, 8'd0); chk("sat_dn1_tc", {7'd0, tca}, 8'd1);
    step(); chk("sat_dn2_q", {4'd0, qa}, 8'd0); chk("sat_dn2_tc", {7'd0, tca}, 8'd1);
`else
    step(); chk("dn4a_q", {4'd0, qa}, 8'd8); chk("dn4a_tc", {7'd0, tca}, 8'd1);
    step(); chk("dn4b_q", {4'd0, qa}, 8'd4); chk("dn4b_tc", {7'd0, tca}, 8'd0);
`endif

    // Down wrap with INCR=1 from 1
    en = 1'b0; load = 1'b1; D = 4'd1;
    step();
    chk("load1", {4'd0, qb}, 8'd1);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    step(); chk("dn1_q", {4'd0, qb}, 8'd0); chk("dn1_tc", {7'd0, tcb}, 8'd0);
`ifdef STEP_COUNTER_SAT_EN
    step(); chk("sat_dn1b_q", {4'd0, qb}, 8'd0); chk("sat_dn1b_tc", {7'd0, tcb}, 8'd1);
`else
    step(); chk("dn2_q", {4'd0, qb}, 8'd9); chk("dn2_tc", {7'd0, tcb}, 8'd1);
    step(); chk("dn3_q", {4'd0, qb}, 8'd8); chk("dn3_tc", {7'd0, tcb}, 8'd0);
`endif

    // Prescale by 3 with two en-low cycles after the first tick
    en = 1'b0; load = 1'b1; D = 4'd0;
    step();
    load = 1'b0; en = 1'b1; dir = 1'b1;
    step(); chk("ps_en1", {4'd0, qc}, 8'd0);
    step(); chk("ps_en2", {4'd0, qc}, 8'd0);
    step(); chk("ps_en3", {4'd0, qc}, 8'd1); chk("ps_en3_tc", {7'd0, tcc}, 8'd0);
    en = 1'b0;
    step(); step(); chk("ps_gap", {4'd0, qc}, 8'd1);
    en = 1'b1;
    step(); chk("ps_en4", {4'd0, qc}, 8'd1);
    step(); chk("ps_en5", {4'd0, qc}, 8'd1);
    step(); chk("ps_en6", {4'd0, qc}, 8'd2);

    // Reset mid-count discards the partial prescale count
    step();
    rst = 1'b1;
    step(); chk("ps_rst", {4'd0, qc}, 8'd3);
    rst = 1'b0;
    step(); step(); chk("ps_after_rst2", {4'd0, qc}, 8'd3);
    step(); chk("ps_after_rst3", {4'd0, qc}, 8'd4);

    // Priority: load over tick with clamp, then clr over load
    en = 1'b0; load = 1'b1; D = 4'd5; dir = 1'b1;
    step(); chk("prio_load5", {4'd0, qa}, 8'd5);
    D = 4'd15; en = 1'b1;
    step(); chk("prio_clamp_q", {4'd0, qa}, 8'd9); chk("prio_clamp_tc", {7'd0, tca}, 8'd0);
    clr = 1'b1;
    step(); chk("prio_clr_q", {4'd0, qa}, 8'd3); chk("prio_clr_tc", {7'd0, tca}, 8'd0);
    clr = 1'b0; load = 1'b0; en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_counter.md
# step_counter

Parametrised up/down step counter with modulo wrap, clock-enable prescaler and registered terminal-count pulse. It supersedes the plain load/count-up register wherever a bounded range, a down direction or a slowed count rate is required. Typical uses are slot and retry timers, packet byte counters and the modulo pointers in the networking layer. All outputs are registered.

## Interface
Parameters:
- WIDTH, 8, width of D and Q.
- DEFVAL, 0, value of Q after reset or clr; must be ≤ MAXVAL.
- INCR, 1, step magnitude per tick; 1 ≤ INCR ≤ MAXVAL.
- MAXVAL, 2**WIDTH-1, upper bound of the count range 0..MAXVAL; must be < 2**WIDTH.
- PRESCALE, 1, number of qualifying en cycles per tick; must be ≥ 1.

Ports:
- clk, input, 1, rising-edge clock; the block's only clock.
- rst, input, 1, synchronous, active-high reset.
- clr, input, 1, synchronous clear of Q to DEFVAL.
- load, input, 1, load Q from D.
- D, input, WIDTH, load value.
- en, input, 1, count enable; feeds the prescaler.
- dir, input, 1, count direction; 1 = up, 0 = down.
- Q, output, WIDTH, count value.
- tc, output, 1, terminal-count pulse.

## Operation
- Reset values: Q = DEFVAL, tc = 0, prescale count pcnt = 0.
- Priority on each clk edge, highest first: rst, then clr, then load, then tick, then hold.
- clr:
  - Q ← DEFVAL, pcnt ← 0, tc ← 0.
- load:
  - Q ← min(D, MAXVAL), so out-of-range loads clamp to MAXVAL.
  - pcnt ← 0, tc ← 0.
- Prescaler:
  - pcnt is max(1, $clog2(PRESCALE)) bits wide.
  - On an en cycle with pcnt == PRESCALE-1, a tick occurs and pcnt ← 0.
  - On any other en cycle, pcnt increments and no tick occurs.
  - With en low, pcnt holds.
  - With PRESCALE = 1, every en cycle is a tick.
- Tick up (dir = 1):
  - Arithmetic is done in WIDTH+1 bits.
  - If Q + INCR ≤ MAXVAL: Q ← Q + INCR, tc ← 0.
  - Otherwise (wrap): Q ← Q + INCR − (MAXVAL+1), tc ← 1.
- Tick down (dir = 0):
  - If Q ≥ INCR: Q ← Q − INCR, tc ← 0.
  - Otherwise (wrap): Q ← Q + (MAXVAL+1) − INCR, tc ← 1.
- Non-tick cycles: tc ← 0, Q holds.
- dir may change on any cycle; only its value on a tick edge matters.

## Timing
- Load and clr: Q shows the new value in the cycle after the edge that samples load or clr (1-cycle latency).
- Tick: Q and tc update on the same edge; tc is high for exactly the one cycle in which Q shows the wrapped value.
- Back-to-back wraps, e.g. INCR = MAXVAL with en held high, keep tc high on consecutive cycles.
- Simultaneous load and en: load wins, no tick occurs, pcnt restarts from 0.
- rst mid-count: on the next edge all state returns to reset values and any partial prescale count is discarded.
- No combinational path exists from any input to any output.

## Configuration
- Macro: STEP_COUNTER_SAT_EN.
- Defined (saturating mode):
  - Up past the bound: Q ← MAXVAL, tc ← 1.
  - Down past the bound: Q ← 0, tc ← 1.
  - A tick while already at the bound in the tick direction leaves Q unchanged and pulses tc again.
  - All other behaviour is unchanged.
- Undefined: modulo wrap exactly as described under Operation.

## Test plan
- Reset and hold (WIDTH=4, DEFVAL=3, MAXVAL=9): assert rst, then en = 0 for 5 cycles -> Q = 3 and tc = 0 throughout.
- Up wrap (MAXVAL=9, INCR=4, Q=8, dir=1, en=1) -> Q sequence 2, 6, 0, 4; tc is 1 on the cycles showing 2 and 0, and 0 on the others.
- Down wrap (MAXVAL=9, INCR=1, Q=1, dir=0) -> Q sequence 0, 9, 8; tc high only while Q = 9.
- Prescale (PRESCALE=3, INCR=1, Q=0, en high except low for 2 cycles after the first tick) -> Q = 1 at the third en cycle and Q = 2 at the sixth en cycle; the en-low cycles do not advance pcnt.
- Priority (Q=5, load=1 with D=15 and MAXVAL=9, en=1, same cycle) -> Q = 9 and tc = 0. Next cycle, clr=1 and load=1 together -> Q = DEFVAL.
- Saturation (STEP_COUNTER_SAT_EN defined, MAXVAL=9, INCR=4, Q=8, dir=1, 2 ticks) -> Q = 9, 9 with tc = 1, 1. Then dir=0, INCR=4, from Q=2 -> Q = 0 with tc = 1.
